// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared types and constants for the memory arbiter.
//   - arb_state_e : arbiter FSM states
//   - owner_e     : grant owner (instruction refill or data access)
//   - beat_width(): beat-counter width for a given refill line length
package memory_arbiter_pkg;

  localparam int unsigned AddrW  = 30;  // word address [31:2]
  localparam int unsigned DataW  = 32;
  localparam int unsigned BeW    = 4;
  localparam int unsigned BeatOW = 4;   // width of the ic_beat_o port

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIcBurst = 2'd1,
    StDcXfer  = 2'd2,
    StResp    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OwnerIc = 1'b0,
    OwnerDc = 1'b1
  } owner_e;

  // Beat-counter width; at least one bit so degenerate lines still elaborate.
  function automatic int unsigned beat_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: bundles the I-cache refill, D-cache access and memory port signals.
//   master : arbiter view (takes cache requests, drives the memory port)
//   slave  : environment view (caches and memory/bus bridge)
interface memory_arbiter_if;
  import memory_arbiter_pkg::*;

  // Instruction-cache refill side
  logic              ic_req_i;
  logic [AddrW-1:0]  ic_addr_i;
  logic              ic_valid_o;
  logic [BeatOW-1:0] ic_beat_o;
  logic [DataW-1:0]  ic_rdata_o;
  logic              ic_done_o;
  logic              ic_err_o;

  // Data-cache side
  logic              dc_req_i;
  logic [BeW-1:0]    dc_we_i;
  logic [AddrW-1:0]  dc_addr_i;
  logic [DataW-1:0]  dc_wdata_i;
  logic [DataW-1:0]  dc_rdata_o;
  logic              dc_ack_o;
  logic              dc_err_o;

  // Memory port
  logic              mem_req_o;
  logic [BeW-1:0]    mem_we_o;
  logic [AddrW-1:0]  mem_addr_o;
  logic [DataW-1:0]  mem_wdata_o;
  logic [DataW-1:0]  mem_rdata_i;
  logic              mem_ack_i;

  modport master (
    input  ic_req_i, ic_addr_i,
    output ic_valid_o, ic_beat_o, ic_rdata_o, ic_done_o, ic_err_o,
    input  dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
    output dc_rdata_o, dc_ack_o, dc_err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    output ic_req_i, ic_addr_i,
    input  ic_valid_o, ic_beat_o, ic_rdata_o, ic_done_o, ic_err_o,
    output dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
    input  dc_rdata_o, dc_ack_o, dc_err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );

endinterface

// File: rtl/arb_watchdog.sv
// arb_watchdog: transfer timeout counter for a bus master.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   en_i         : a transfer is outstanding; counter runs
//   clr_i        : progress seen (beat acknowledged); counter restarts
//   expire_o     : TIMEOUT_CYCLES consecutive cycles elapsed without progress
// TIMEOUT_CYCLES = 0 disables expiry.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt + 1'b1;
    if (!en_i || clr_i) begin
      w_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  // r_cnt == CntLast means this is the TIMEOUT_CYCLES-th cycle without an ack.
  assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && !clr_i && (r_cnt == CntLast);

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one word-wide memory port between I-cache line refills and
// D-cache single-word accesses, round-robin on ties, with a per-transfer watchdog.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : memory_arbiter_if.master
//                  ic_*  : line refill request, per-beat data, done/err
//                  dc_*  : single read / byte-enabled write, ack/err
//                  mem_* : external memory request and response
// All outputs are registered.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned IC_LINE_WORDS  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  memory_arbiter_if.master        bus
);

  localparam int unsigned        BeatW    = beat_width(IC_LINE_WORDS);
  localparam logic [BeatW-1:0]   LastBeat = BeatW'(IC_LINE_WORDS - 1);

  arb_state_e        r_state, w_state_d;
  owner_e            r_last, w_last_d;
  logic [BeatW-1:0]  r_beat, w_beat_d;

  logic              r_mem_req, w_mem_req_d;
  logic [BeW-1:0]    r_mem_we, w_mem_we_d;
  logic [AddrW-1:0]  r_mem_addr, w_mem_addr_d;
  logic [DataW-1:0]  r_mem_wdata, w_mem_wdata_d;
  logic              r_ic_valid, w_ic_valid_d;
  logic [BeatOW-1:0] r_ic_beat, w_ic_beat_d;
  logic [DataW-1:0]  r_ic_rdata, w_ic_rdata_d;
  logic              r_ic_done, w_ic_done_d;
  logic              r_ic_err, w_ic_err_d;
  logic [DataW-1:0]  r_dc_rdata, w_dc_rdata_d;
  logic              r_dc_ack, w_dc_ack_d;
  logic              r_dc_err, w_dc_err_d;

  logic              w_wd_en;
  logic              w_wd_expire;

  assign w_wd_en = (r_state == StIcBurst) || (r_state == StDcXfer);

  arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (w_wd_en),
    .clr_i    (bus.mem_ack_i),
    .expire_o (w_wd_expire)
  );

  always_comb begin
    w_state_d     = r_state;
    w_last_d      = r_last;
    w_beat_d      = r_beat;
    w_mem_req_d   = r_mem_req;
    w_mem_we_d    = r_mem_we;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    w_ic_beat_d   = r_ic_beat;
    w_ic_rdata_d  = r_ic_rdata;
    w_dc_rdata_d  = r_dc_rdata;
    // Pulse outputs default low every cycle.
    w_ic_valid_d  = 1'b0;
    w_ic_done_d   = 1'b0;
    w_ic_err_d    = 1'b0;
    w_dc_ack_d    = 1'b0;
    w_dc_err_d    = 1'b0;

    unique case (r_state)
      StIdle: begin
        // DC wins when alone, or on a tie when IC had the previous grant.
        if (bus.dc_req_i && (!bus.ic_req_i || (r_last == OwnerIc))) begin
          w_state_d     = StDcXfer;
          w_last_d      = OwnerDc;
          w_mem_req_d   = 1'b1;
          w_mem_addr_d  = bus.dc_addr_i;
          w_mem_we_d    = bus.dc_we_i;
          w_mem_wdata_d = bus.dc_wdata_i;
        end else if (bus.ic_req_i) begin
          w_state_d    = StIcBurst;
          w_last_d     = OwnerIc;
          w_beat_d     = '0;
          w_mem_req_d  = 1'b1;
          w_mem_we_d   = '0;
          w_mem_addr_d = bus.ic_addr_i;
          w_mem_addr_d[BeatW-1:0] = '0;  // line-aligned base
        end
      end

      StDcXfer: begin
        if (bus.mem_ack_i) begin
          w_state_d    = StResp;
          w_dc_rdata_d = bus.mem_rdata_i;
          w_dc_ack_d   = 1'b1;
          w_mem_req_d  = 1'b0;
          w_mem_we_d   = '0;
        end else if (w_wd_expire) begin
          w_state_d    = StResp;
          w_dc_rdata_d = '0;
          w_dc_ack_d   = 1'b1;
          w_dc_err_d   = 1'b1;
          w_mem_req_d  = 1'b0;
          w_mem_we_d   = '0;
        end
      end

      StIcBurst: begin
        if (bus.mem_ack_i) begin
          w_ic_rdata_d = bus.mem_rdata_i;
          w_ic_beat_d  = BeatOW'(r_beat);
          w_ic_valid_d = 1'b1;
          if (r_beat == LastBeat) begin
            w_state_d   = StResp;
            w_beat_d    = '0;
            w_mem_req_d = 1'b0;
            w_ic_done_d = 1'b1;
          end else begin
            // Only the low beat bits advance; the line base is untouched.
            w_beat_d = r_beat + 1'b1;
            w_mem_addr_d[BeatW-1:0] = w_beat_d;
          end
        end else if (w_wd_expire) begin
          w_state_d   = StResp;
          w_beat_d    = '0;
          w_mem_req_d = 1'b0;
          w_ic_done_d = 1'b1;
          w_ic_err_d  = 1'b1;
        end
      end

      // One dead cycle so a requester can drop req after its done/ack.
      StResp: begin
        w_state_d = StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_last      <= OwnerIc;
      r_beat      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ic_valid  <= 1'b0;
      r_ic_beat   <= '0;
      r_ic_rdata  <= '0;
      r_ic_done   <= 1'b0;
      r_ic_err    <= 1'b0;
      r_dc_rdata  <= '0;
      r_dc_ack    <= 1'b0;
      r_dc_err    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_last      <= w_last_d;
      r_beat      <= w_beat_d;
      r_mem_req   <= w_mem_req_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_ic_valid  <= w_ic_valid_d;
      r_ic_beat   <= w_ic_beat_d;
      r_ic_rdata  <= w_ic_rdata_d;
      r_ic_done   <= w_ic_done_d;
      r_ic_err    <= w_ic_err_d;
      r_dc_rdata  <= w_dc_rdata_d;
      r_dc_ack    <= w_dc_ack_d;
      r_dc_err    <= w_dc_err_d;
    end
  end

  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;
  assign bus.ic_valid_o  = r_ic_valid;
  assign bus.ic_beat_o   = r_ic_beat;
  assign bus.ic_rdata_o  = r_ic_rdata;
  assign bus.ic_done_o   = r_ic_done;
  assign bus.ic_err_o    = r_ic_err;
  assign bus.dc_rdata_o  = r_dc_rdata;
  assign bus.dc_ack_o    = r_dc_ack;
  assign bus.dc_err_o    = r_dc_err;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed, table-driven bench for memory_arbiter
// (IC_LINE_WORDS = 4, TIMEOUT_CYCLES = 8).
module tb_memory_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_arbiter_if bus();

  memory_arbiter #(
    .IC_LINE_WORDS  (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  typedef struct {
    bit          is_ic;
    logic [29:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    int unsigned lat;       // cycles from grant (or previous beat) to ack
    logic [31:0] rdata;     // memory data; beat b of a refill returns rdata+b
    logic [29:0] exp_addr;  // expected mem_addr_o at grant
    logic [3:0]  exp_we;    // expected mem_we_o at grant
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_req"},   32'(bus.mem_req_o),   32'd0);
    chk({tag, ".mem_we"},    32'(bus.mem_we_o),    32'd0);
    chk({tag, ".mem_addr"},  32'(bus.mem_addr_o),  32'd0);
    chk({tag, ".mem_wdata"}, bus.mem_wdata_o,      32'd0);
    chk({tag, ".ic_valid"},  32'(bus.ic_valid_o),  32'd0);
    chk({tag, ".ic_beat"},   32'(bus.ic_beat_o),   32'd0);
    chk({tag, ".ic_rdata"},  bus.ic_rdata_o,       32'd0);
    chk({tag, ".ic_done"},   32'(bus.ic_done_o),   32'd0);
    chk({tag, ".ic_err"},    32'(bus.ic_err_o),    32'd0);
    chk({tag, ".dc_rdata"},  bus.dc_rdata_o,       32'd0);
    chk({tag, ".dc_ack"},    32'(bus.dc_ack_o),    32'd0);
    chk({tag, ".dc_err"},    32'(bus.dc_err_o),    32'd0);
  endtask

  // The cycle after a completion: nothing requested, no pulses repeated.
  task automatic resp_step(input string tag);
    step();
    chk({tag, ".resp.mem_req"},  32'(bus.mem_req_o),  32'd0);
    chk({tag, ".resp.dc_ack"},   32'(bus.dc_ack_o),   32'd0);
    chk({tag, ".resp.dc_err"},   32'(bus.dc_err_o),   32'd0);
    chk({tag, ".resp.ic_valid"}, 32'(bus.ic_valid_o), 32'd0);
    chk({tag, ".resp.ic_done"},  32'(bus.ic_done_o),  32'd0);
    chk({tag, ".resp.ic_err"},   32'(bus.ic_err_o),   32'd0);
  endtask

  task automatic grant_check(input string tag, input logic [29:0] addr, input logic [3:0] we);
    chk({tag, ".grant.mem_req"},  32'(bus.mem_req_o),  32'd1);
    chk({tag, ".grant.mem_addr"}, 32'(bus.mem_addr_o), 32'(addr));
    chk({tag, ".grant.mem_we"},   32'(bus.mem_we_o),   32'(we));
  endtask

  task automatic dc_finish(input string tag, input int unsigned lat, input logic [31:0] rdata);
    for (int i = 1; i < int'(lat); i++) begin
      bus.mem_ack_i = 1'b0;
      step();
      chk({tag, ".wait.mem_req"}, 32'(bus.mem_req_o), 32'd1);
      chk({tag, ".wait.dc_ack"},  32'(bus.dc_ack_o),  32'd0);
    end
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = rdata;
    step();
    chk({tag, ".dc_ack"},   32'(bus.dc_ack_o),   32'd1);
    chk({tag, ".dc_err"},   32'(bus.dc_err_o),   32'd0);
    chk({tag, ".dc_rdata"}, bus.dc_rdata_o,      rdata);
    chk({tag, ".done.mem_req"}, 32'(bus.mem_req_o), 32'd0);
    chk({tag, ".done.mem_we"},  32'(bus.mem_we_o),  32'd0);
    bus.mem_ack_i = 1'b0;
    bus.dc_req_i  = 1'b0;
  endtask

  task automatic ic_finish(input string tag, input logic [29:0] base, input int unsigned lat,
                           input logic [31:0] rdata0);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("%s.beat%0d.mem_addr", tag, b), 32'(bus.mem_addr_o), 32'(base + 30'(b)));
      for (int i = 1; i < int'(lat); i++) begin
        bus.mem_ack_i = 1'b0;
        step();
        chk($sformatf("%s.beat%0d.wait.mem_req", tag, b), 32'(bus.mem_req_o), 32'd1);
        chk($sformatf("%s.beat%0d.wait.ic_valid", tag, b), 32'(bus.ic_valid_o), 32'd0);
      end
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = rdata0 + 32'(b);
      step();
      chk($sformatf("%s.beat%0d.ic_valid", tag, b), 32'(bus.ic_valid_o), 32'd1);
      chk($sformatf("%s.beat%0d.ic_beat", tag, b),  32'(bus.ic_beat_o),  32'(b));
      chk($sformatf("%s.beat%0d.ic_rdata", tag, b), bus.ic_rdata_o,      rdata0 + 32'(b));
      chk($sformatf("%s.beat%0d.ic_done", tag, b),  32'(bus.ic_done_o),  32'(b == 3));
      chk($sformatf("%s.beat%0d.ic_err", tag, b),   32'(bus.ic_err_o),   32'd0);
      chk($sformatf("%s.beat%0d.mem_req", tag, b),  32'(bus.mem_req_o),  32'(b != 3));
    end
    bus.mem_ack_i = 1'b0;
    bus.ic_req_i  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    bus.ic_req_i    = 1'b0;
    bus.ic_addr_i   = '0;
    bus.dc_req_i    = 1'b0;
    bus.dc_we_i     = '0;
    bus.dc_addr_i   = '0;
    bus.dc_wdata_i  = '0;
    bus.mem_rdata_i = '0;
    bus.mem_ack_i   = 1'b0;

    vecs[0] = '{is_ic: 1'b0, addr: 30'h40, we: 4'h0, wdata: 32'h0, lat: 2,
                rdata: 32'hDEADBEEF, exp_addr: 30'h40, exp_we: 4'h0};
    vecs[1] = '{is_ic: 1'b1, addr: 30'h47, we: 4'h0, wdata: 32'h0, lat: 1,
                rdata: 32'hA0, exp_addr: 30'h44, exp_we: 4'h0};
    vecs[2] = '{is_ic: 1'b0, addr: 30'h1234, we: 4'b0011, wdata: 32'h12345678, lat: 1,
                rdata: 32'h0BADF00D, exp_addr: 30'h1234, exp_we: 4'b0011};
    vecs[3] = '{is_ic: 1'b1, addr: 30'h3FFFFFFF, we: 4'h0, wdata: 32'h0, lat: 3,
                rdata: 32'h100, exp_addr: 30'h3FFFFFFC, exp_we: 4'h0};
    vecs[4] = '{is_ic: 1'b0, addr: 30'h3FFFFFFF, we: 4'hF, wdata: 32'hA5A5A5A5, lat: 7,
                rdata: 32'h55AA55AA, exp_addr: 30'h3FFFFFFF, exp_we: 4'hF};

    // Reset state
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;

    // Acks with no transfer outstanding are ignored
    bus.mem_ack_i = 1'b1;
    step();
    step();
    chk("idle_ack.mem_req",  32'(bus.mem_req_o),  32'd0);
    chk("idle_ack.dc_ack",   32'(bus.dc_ack_o),   32'd0);
    chk("idle_ack.ic_valid", 32'(bus.ic_valid_o), 32'd0);
    bus.mem_ack_i = 1'b0;

    // Ties after reset: DC, IC, DC, IC with a RESP cycle between each
    bus.dc_addr_i = 30'h100;
    bus.dc_we_i   = 4'h0;
    bus.ic_addr_i = 30'h200;
    bus.dc_req_i  = 1'b1;
    bus.ic_req_i  = 1'b1;
    step();
    grant_check("tie1_dc", 30'h100, 4'h0);
    dc_finish("tie1_dc", 1, 32'h11111111);
    resp_step("tie1_dc");
    bus.dc_req_i = 1'b1;
    step();
    grant_check("tie2_ic", 30'h200, 4'h0);
    ic_finish("tie2_ic", 30'h200, 1, 32'hB0);
    resp_step("tie2_ic");
    bus.ic_req_i = 1'b1;
    step();
    grant_check("tie3_dc", 30'h100, 4'h0);
    dc_finish("tie3_dc", 1, 32'h22222222);
    resp_step("tie3_dc");
    bus.dc_req_i = 1'b1;
    step();
    grant_check("tie4_ic", 30'h200, 4'h0);
    ic_finish("tie4_ic", 30'h200, 1, 32'hB8);
    bus.dc_req_i = 1'b0;
    resp_step("tie4_ic");

    // Table of single transfers
    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (vecs[i].is_ic) begin
        bus.ic_addr_i = vecs[i].addr;
        bus.ic_req_i  = 1'b1;
        step();
        grant_check(tag, vecs[i].exp_addr, vecs[i].exp_we);
        ic_finish(tag, vecs[i].exp_addr, vecs[i].lat, vecs[i].rdata);
      end else begin
        bus.dc_addr_i  = vecs[i].addr;
        bus.dc_we_i    = vecs[i].we;
        bus.dc_wdata_i = vecs[i].wdata;
        bus.dc_req_i   = 1'b1;
        step();
        grant_check(tag, vecs[i].exp_addr, vecs[i].exp_we);
        chk({tag, ".mem_wdata"}, bus.mem_wdata_o, vecs[i].wdata);
        dc_finish(tag, vecs[i].lat, vecs[i].rdata);
      end
      resp_step(tag);
    end

    // DC timeout with an IC request pending behind it
    bus.dc_addr_i = 30'h80;
    bus.dc_we_i   = 4'h0;
    bus.dc_req_i  = 1'b1;
    step();
    grant_check("dc_to", 30'h80, 4'h0);
    bus.ic_addr_i = 30'h10;
    bus.ic_req_i  = 1'b1;
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("dc_to.cyc%0d.mem_req", i), 32'(bus.mem_req_o), 32'd1);
      chk($sformatf("dc_to.cyc%0d.dc_ack", i),  32'(bus.dc_ack_o),  32'd0);
    end
    step();
    chk("dc_to.mem_req",  32'(bus.mem_req_o), 32'd0);
    chk("dc_to.dc_ack",   32'(bus.dc_ack_o),  32'd1);
    chk("dc_to.dc_err",   32'(bus.dc_err_o),  32'd1);
    chk("dc_to.dc_rdata", bus.dc_rdata_o,     32'd0);
    bus.dc_req_i = 1'b0;
    resp_step("dc_to");
    step();
    grant_check("dc_to.next_ic", 30'h10, 4'h0);

    // IC timeout after the first beat
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'hC0;
    step();
    chk("ic_to.beat0.ic_valid", 32'(bus.ic_valid_o), 32'd1);
    chk("ic_to.beat0.ic_beat",  32'(bus.ic_beat_o),  32'd0);
    bus.mem_ack_i = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("ic_to.cyc%0d.mem_req", i), 32'(bus.mem_req_o), 32'd1);
      chk($sformatf("ic_to.cyc%0d.ic_done", i), 32'(bus.ic_done_o), 32'd0);
    end
    step();
    chk("ic_to.mem_req",  32'(bus.mem_req_o),  32'd0);
    chk("ic_to.ic_done",  32'(bus.ic_done_o),  32'd1);
    chk("ic_to.ic_err",   32'(bus.ic_err_o),   32'd1);
    chk("ic_to.ic_valid", 32'(bus.ic_valid_o), 32'd0);
    bus.ic_req_i = 1'b0;
    resp_step("ic_to");

    // A fresh refill after the aborted one starts again from beat 0
    bus.ic_req_i = 1'b1;
    step();
    grant_check("ic_retry", 30'h10, 4'h0);
    ic_finish("ic_retry", 30'h10, 1, 32'hD0);
    resp_step("ic_retry");

    // Asynchronous reset during beat 2 of a refill
    bus.ic_addr_i = 30'h20;
    bus.ic_req_i  = 1'b1;
    step();
    grant_check("rst_mid", 30'h20, 4'h0);
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'hE0;
    step();
    bus.mem_rdata_i = 32'hE1;
    step();
    chk("rst_mid.beat1.ic_beat", 32'(bus.ic_beat_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid.async");
    bus.mem_ack_i = 1'b0;
    bus.ic_req_i  = 1'b0;
    step();
    step();
    rst = 1'b0;

    // First tie after reset goes to DC again
    bus.dc_addr_i = 30'h300;
    bus.dc_we_i   = 4'h0;
    bus.dc_req_i  = 1'b1;
    bus.ic_req_i  = 1'b1;
    step();
    grant_check("post_rst_dc", 30'h300, 4'h0);
    dc_finish("post_rst_dc", 1, 32'h77);
    resp_step("post_rst_dc");
    step();
    grant_check("post_rst_ic", 30'h20, 4'h0);
    ic_finish("post_rst_ic", 30'h20, 1, 32'hF0);
    resp_step("post_rst_ic");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
